// File: rtl/bit32_select_pkg.sv
// Shared constants for the bit32_select unit.
// State encodings and field widths.
package bit32_select_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int SEL_POS_W  = 5;
  localparam int SEL_RANK_W = 6;

endpackage

// File: rtl/bit8_popcount.sv
// 8-bit population count.
// Purely combinational, result 0..8.
module bit8_popcount (
  input  logic [7:0] b,
  output logic [3:0] c
);

  // Sum the set bits of the byte.
  always_comb begin
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, b[i]};
    end
  end

endmodule

// File: rtl/bit8_select.sv
// Position of the rank-th set bit in a byte.
// Output is don't-care when rank exceeds popcount.
module bit8_select (
  input  logic [7:0] b,
  input  logic [3:0] rank,
  output logic [2:0] off
);

  logic [3:0] cnt;

  // Running count of set bits; the bit where it reaches rank wins.
  always_comb begin
    off = '0;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        cnt = cnt + 4'd1;
        if (cnt == rank) begin
          off = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/bit32_select.sv
// Multi-cycle bit-select: position of the k-th set bit of a.
// Scans one byte per cycle with start/busy/done handshake.
module bit32_select
  import bit32_select_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [5:0]  k,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] pos
);

  logic [1:0]            state;
  logic [31:0]           w;
  logic [SEL_RANK_W-1:0] r;
  logic [1:0]            byte_idx;
  logic                  inv;

  logic [7:0] b;
  logic [3:0] c;
  logic [2:0] off;
  logic       hit;

  assign b   = w[{byte_idx, 3'b000} +: 8];
  assign hit = ({2'b00, c} >= r);

  bit8_popcount u_pc (
    .b (b),
    .c (c)
  );

  bit8_select u_sel (
    .b    (b),
    .rank (r[3:0]),
    .off  (off)
  );

  // Control FSM; an invalid rank spends one scan cycle so its
  // latency matches a byte-0 hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      w        <= '0;
      r        <= '0;
      byte_idx <= '0;
      inv      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      pos      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            w        <= a;
            r        <= k;
            byte_idx <= '0;
            inv      <= (k == 6'd0) || (k > 6'd32);
            busy     <= 1'b1;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (inv) begin
            found <= 1'b0;
            pos   <= '0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (hit) begin
            found <= 1'b1;
            pos   <= {{(32-SEL_POS_W){1'b0}}, byte_idx, off};
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (byte_idx == 2'd3) begin
            found <= 1'b0;
            pos   <= '0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            r        <= r - {2'b00, c};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit32_select.sv
// Bench for bit32_select: vector table, random
// requests against a bit-walk model, handshake/reset cases.
module tb_bit32_select;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [5:0]  k;
  logic        busy;
  logic        done;
  logic        found;
  logic [31:0] pos;

  int checks = 0;
  int failures = 0;

  bit32_select dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .k     (k),
    .busy  (busy),
    .done  (done),
    .found (found),
    .pos   (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [5:0]  vk;
    logic        ef;
    logic [31:0] ep;
    int          el;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Walk the word bit by bit counting set bits.
  function automatic void model(input logic [31:0] ma,
                                input logic [5:0] mk,
                                output logic f,
                                output logic [31:0] p,
                                output int l);
    int cnt;
    f = 1'b0;
    p = 0;
    l = 4;
    if (mk == 0 || mk > 32) begin
      l = 1;
      return;
    end
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (ma[i]) begin
        cnt++;
        if (cnt == int'(mk)) begin
          f = 1'b1;
          p = i;
          l = i / 8 + 1;
          return;
        end
      end
    end
  endfunction

  // One request; n counts edges after the accepting edge.
  task automatic do_req(input logic [31:0] ta, input logic [5:0] tk,
                        input logic ef, input logic [31:0] ep,
                        input int el, input string nm);
    int n;
    int bc;
    bit got;
    @(negedge clk);
    a = ta;
    k = tk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    k = 6'($urandom);
    n = 0;
    bc = 0;
    got = 0;
    while (!got && n <= 10) begin
      if (busy) bc++;
      if (done) got = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk({nm, " done_seen"}, 32'(got), 32'd1);
    chk({nm, " latency"}, n, el);
    chk({nm, " busy_cycles"}, bc, el + 1);
    chk({nm, " found"}, 32'(found), 32'(ef));
    chk({nm, " pos"}, pos, ep);
    @(negedge clk);
    chk({nm, " done_pulse"}, 32'(done), 32'd0);
    chk({nm, " busy_drop"}, 32'(busy), 32'd0);
    chk({nm, " pos_hold"}, pos, ep);
  endtask

  initial begin
    logic        mf;
    logic [31:0] mp;
    int          ml;
    logic [31:0] ra;
    logic [5:0]  rk;
    int          dq[$];
    bit          sawdone;

    tbl[0] = '{32'h0000_0001, 6'd1,  1'b1, 32'd0,  1};
    tbl[1] = '{32'h8000_0000, 6'd1,  1'b1, 32'd31, 4};
    tbl[2] = '{32'hFFFF_FFFF, 6'd32, 1'b1, 32'd31, 4};
    tbl[3] = '{32'hFFFF_FFFF, 6'd9,  1'b1, 32'd8,  2};
    tbl[4] = '{32'hA5A5_A5A5, 6'd7,  1'b1, 32'd13, 2};
    tbl[5] = '{32'h0000_00F0, 6'd5,  1'b0, 32'd0,  4};
    tbl[6] = '{32'hFFFF_FFFF, 6'd0,  1'b0, 32'd0,  1};
    tbl[7] = '{32'hFFFF_FFFF, 6'd33, 1'b0, 32'd0,  1};
    tbl[8] = '{32'hFFFF_FFFF, 6'd63, 1'b0, 32'd0,  1};
    tbl[9] = '{32'h0000_0000, 6'd1,  1'b0, 32'd0,  4};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    k = '0;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset found", 32'(found), 32'd0);
    chk("reset pos", pos, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_req(tbl[i].va, tbl[i].vk, tbl[i].ef, tbl[i].ep,
             tbl[i].el, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      if (i % 3 == 1) ra = ra & $urandom & $urandom;
      if (i % 3 == 2) ra = ra & 32'hFF00_0000;
      rk = 6'($urandom_range(0, 40));
      model(ra, rk, mf, mp, ml);
      do_req(ra, rk, mf, mp, ml, $sformatf("rnd%0d", i));
    end

    // start held high: accepted every 3 cycles for a byte-0 hit
    @(negedge clk);
    a = 32'h0000_0001;
    k = 6'd1;
    start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dq.push_back(i);
    end
    start = 1'b0;
    chk("held count", dq.size(), 5);
    for (int j = 0; j < dq.size() && j < 5; j++) begin
      chk($sformatf("held done%0d", j), dq[j], 1 + 3 * j);
    end
    repeat (3) @(negedge clk);

    // second start during SCAN and DONE is ignored
    @(negedge clk);
    a = 32'h8000_0000;
    k = 6'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    sawdone = 0;
    for (int i = 0; i < 4; i++) begin
      a = 32'h0000_0001;
      k = 6'd1;
      start = 1'b1;
      if (done) sawdone = 1;
      if (!done) @(negedge clk);
    end
    chk("ign done", 32'(done), 32'd1);
    chk("ign found", 32'(found), 32'd1);
    chk("ign pos", pos, 32'd31);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign no_rerun", 32'(busy), 32'd0);
    chk("ign held pos", pos, 32'd31);
    chk("ign held found", 32'(found), 32'd1);

    // reset during SCAN of byte 2
    @(negedge clk);
    a = 32'h8000_0000;
    k = 6'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst found", 32'(found), 32'd0);
    chk("rst pos", pos, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sawdone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) sawdone = 1;
    end
    chk("rst no_done", 32'(sawdone), 32'd0);
    do_req(32'hA5A5_A5A5, 6'd7, 1'b1, 32'd13, 2, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
